// File: rtl/pla_sweep_checker.sv
// ----------------------------------------------------------------------------
// pla_sweep_checker
//
// Exhaustive stimulus-and-compare stage for a combinational (or shallowly
// registered) PLA-derived DUT. After a start pulse it presents every input
// vector 0 .. 2^N_IN-1 in order, one per cycle. It samples the DUT outputs,
// compares them against a golden truth-table ROM and accumulates mismatch
// statistics. These statistics are the fitness figure for an evolved circuit.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start_i             start pulse, honoured only in IDLE or DONE
//   vec_o/vec_valid_o   stimulus vector towards the DUT and its qualifier
//   po_i                DUT primary outputs
//   golden_addr_o       golden ROM address (mirrors vec_o)
//   golden_data_i       golden ROM data, one-cycle synchronous read
//   busy_o / done_o     sweep-or-drain in progress / results valid
//   err_cnt_o           per-output mismatch counters, output j in slice j
//   fail_cnt_o          number of vectors with any mismatching output
//   first_fail_o(+_valid_o) lowest failing vector index
//
// Parameters
//   N_IN     number of DUT inputs (sweep length 2^N_IN)
//   N_OUT    number of DUT outputs compared
//   DUT_LAT  DUT register latency in cycles (0..4)
// ----------------------------------------------------------------------------
module pla_sweep_checker #(
    parameter int N_IN    = 11,
    parameter int N_OUT   = 2,
    parameter int DUT_LAT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic [N_IN-1:0]           vec_o,
    output logic                      vec_valid_o,
    input  logic [N_OUT-1:0]          po_i,
    output logic [N_IN-1:0]           golden_addr_o,
    input  logic [N_OUT-1:0]          golden_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [N_OUT*(N_IN+1)-1:0] err_cnt_o,
    output logic [N_IN:0]             fail_cnt_o,
    output logic [N_IN-1:0]           first_fail_o,
    output logic                      first_fail_valid_o
);

    // Counters are one bit wider than the vector so 2^N_IN fits without wrap.
    localparam int              CW         = N_IN + 1;
    // Vector valid/index must line up with the registered DUT output.
    localparam int              PL         = DUT_LAT + 1;
    localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};
    localparam logic [2:0]      DRAIN_LAST = 3'(DUT_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [N_IN-1:0]            vec_q, vec_d;
    logic                       vec_valid_q, vec_valid_d;
    logic [2:0]                 drain_q, drain_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [N_OUT-1:0][CW-1:0]   err_q, err_d;
    logic [CW-1:0]              fail_q, fail_d;
    logic [N_IN-1:0]            ff_q, ff_d;
    logic                       ffv_q, ffv_d;

    // Compare pipeline
    logic [N_OUT-1:0]           po_q;
    logic [PL-1:0]              vld_q, vld_d;
    logic [N_IN-1:0]            idx_q [PL];
    logic [N_IN-1:0]            idx_d [PL];
    logic [N_OUT-1:0]           gold_cmp_s;
    logic [N_OUT-1:0]           mism_s;
    logic                       any_mis_s;
    logic                       cmp_vld_s;

    // ------------------------------------------------------------------
    // Golden alignment. The ROM already supplies the data one cycle after
    // the address. That matches a combinational DUT whose output is
    // registered once. Every DUT register stage needs one more golden
    // stage.
    // ------------------------------------------------------------------
    if (DUT_LAT == 0) begin : g_gold_direct
        // No extra golden delay for a combinational DUT.
        always_comb begin
            gold_cmp_s = golden_data_i;
        end
    end else begin : g_gold_pipe
        logic [N_OUT-1:0] gold_q [DUT_LAT];
        logic [N_OUT-1:0] gold_d [DUT_LAT];

        // Golden delay line shift network.
        always_comb begin
            for (int i = 0; i < DUT_LAT; i++) begin
                gold_d[i] = '0;
            end
            gold_d[0] = golden_data_i;
            for (int i = 1; i < DUT_LAT; i++) begin
                gold_d[i] = gold_q[i-1];
            end
            gold_cmp_s = gold_q[DUT_LAT-1];
        end

        // Golden delay line registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < DUT_LAT; i++) begin
                    gold_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DUT_LAT; i++) begin
                    gold_q[i] <= gold_d[i];
                end
            end
        end
    end

    // Valid/index delay line shift network.
    always_comb begin
        vld_d = '0;
        for (int i = 0; i < PL; i++) begin
            idx_d[i] = '0;
        end
        vld_d[0] = vec_valid_q;
        idx_d[0] = vec_q;
        for (int i = 1; i < PL; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // DUT output capture plus valid/index delay line registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            po_q  <= '0;
            vld_q <= '0;
            for (int i = 0; i < PL; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            po_q  <= po_i;
            vld_q <= vld_d;
            for (int i = 0; i < PL; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign cmp_vld_s = vld_q[PL-1];
    assign mism_s    = po_q ^ gold_cmp_s;
    assign any_mis_s = |mism_s;

    // Next-state logic: sequencing, statistics accumulation and start clearing.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q;
        drain_d     = drain_q;
        err_d       = err_q;
        fail_d      = fail_q;
        ff_d        = ff_q;
        ffv_d       = ffv_q;

        // A retiring compare updates the statistics in whatever state it lands.
        if (cmp_vld_s) begin
            for (int j = 0; j < N_OUT; j++) begin
                err_d[j] = err_q[j] + CW'(mism_s[j]);
            end
            fail_d = fail_q + CW'(any_mis_s);
            if (any_mis_s && !ffv_q) begin
                ff_d  = idx_q[PL-1];
                ffv_d = 1'b1;
            end else begin
                ff_d  = ff_q;
                ffv_d = ffv_q;
            end
        end else begin
            err_d  = err_q;
            fail_d = fail_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_SWEEP;
                    vec_d       = '0;
                    vec_valid_d = 1'b1;
                    drain_d     = 3'd0;
                    err_d       = '0;
                    fail_d      = '0;
                    ff_d        = '0;
                    ffv_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SWEEP: begin
                if (vec_q == VEC_LAST) begin
                    state_d     = S_DRAIN;
                    vec_d       = '0;
                    vec_valid_d = 1'b0;
                    drain_d     = 3'd0;
                end else begin
                    vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
                end
            end
            S_DRAIN: begin
                // DUT_LAT+1 drain cycles let the last vector's compare retire.
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                vec_d       = '0;
                vec_valid_d = 1'b0;
                drain_d     = 3'd0;
            end
        endcase

        busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            drain_q     <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            fail_q      <= '0;
            ff_q        <= '0;
            ffv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            ff_q        <= ff_d;
            ffv_q       <= ffv_d;
        end
    end

    assign vec_o              = vec_q;
    assign golden_addr_o      = vec_q;
    assign vec_valid_o        = vec_valid_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign err_cnt_o          = err_q;
    assign fail_cnt_o         = fail_q;
    assign first_fail_o       = ff_q;
    assign first_fail_valid_o = ffv_q;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// ----------------------------------------------------------------------------
// Self-checking bench for pla_sweep_checker. Two instances run side by side:
// one has a combinational DUT (DUT_LAT=0) and one has a 3-stage registered
// DUT (DUT_LAT=3). Truth tables are randomized. Expected statistics come
// from a table-level model: for each vector k, the DUT's answer is compared
// with the golden entry.
// ----------------------------------------------------------------------------
module tb_pla_sweep_checker;

    localparam int NV = 2048;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    always #5 clk = ~clk;

    logic [1:0] gold_tab [NV];
    logic [1:0] dut_tab  [NV];
    int         stages3;

    // Instance 0: combinational DUT
    logic [10:0] v0, ga0, ff0;
    logic        vv0, busy0, done0, ffv0;
    logic [1:0]  po0, gd0;
    logic [23:0] err0;
    logic [11:0] fail0;

    // Instance 3: registered DUT
    logic [10:0] v3, ga3, ff3;
    logic        vv3, busy3, done3, ffv3;
    logic [1:0]  po3, gd3, s1, s2, s3;
    logic [23:0] err3;
    logic [11:0] fail3;

    pla_sweep_checker #(.N_IN(11), .N_OUT(2), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .vec_o(v0), .vec_valid_o(vv0), .po_i(po0),
        .golden_addr_o(ga0), .golden_data_i(gd0),
        .busy_o(busy0), .done_o(done0), .err_cnt_o(err0), .fail_cnt_o(fail0),
        .first_fail_o(ff0), .first_fail_valid_o(ffv0)
    );

    pla_sweep_checker #(.N_IN(11), .N_OUT(2), .DUT_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .vec_o(v3), .vec_valid_o(vv3), .po_i(po3),
        .golden_addr_o(ga3), .golden_data_i(gd3),
        .busy_o(busy3), .done_o(done3), .err_cnt_o(err3), .fail_cnt_o(fail3),
        .first_fail_o(ff3), .first_fail_valid_o(ffv3)
    );

    // Environment: synchronous golden ROMs and the DUT models.
    assign po0 = dut_tab[v0];
    always @(posedge clk) begin
        gd0 <= gold_tab[ga0];
        gd3 <= gold_tab[ga3];
        s1  <= dut_tab[v3];
        s2  <= s1;
        s3  <= s2;
    end
    assign po3 = (stages3 == 3) ? s3 : s2;

    int n_checks = 0;
    int n_errors = 0;
    int lat0, lat3;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Table-level reference model. A DUT answering 'shift' vectors ahead
    // sees vector (k+shift) mod 2^N_IN; vec_o sits at 0 during drain.
    task automatic model(input int shift, output int e0, output int e1,
                         output int f, output int ff, output int ffv);
        logic [1:0] m;
        e0 = 0; e1 = 0; f = 0; ff = 0; ffv = 0;
        for (int k = 0; k < NV; k++) begin
            m  = dut_tab[(k + shift) % NV] ^ gold_tab[k];
            e0 += int'(m[0]);
            e1 += int'(m[1]);
            if (m != 2'b00) begin
                f++;
                if (ffv == 0) begin
                    ffv = 1;
                    ff  = k;
                end
            end
        end
    endtask

    task automatic check_results(input string tag, input int shift3);
        int e0, e1, f, ff, ffv;
        model(0, e0, e1, f, ff, ffv);
        check_eq({tag, "_d0_err0"}, int'(err0[11:0]), e0);
        check_eq({tag, "_d0_err1"}, int'(err0[23:12]), e1);
        check_eq({tag, "_d0_fail"}, int'(fail0), f);
        check_eq({tag, "_d0_ffv"}, int'(ffv0), ffv);
        if (ffv != 0) check_eq({tag, "_d0_ff"}, int'(ff0), ff);
        model(shift3, e0, e1, f, ff, ffv);
        check_eq({tag, "_d3_err0"}, int'(err3[11:0]), e0);
        check_eq({tag, "_d3_err1"}, int'(err3[23:12]), e1);
        check_eq({tag, "_d3_fail"}, int'(fail3), f);
        check_eq({tag, "_d3_ffv"}, int'(ffv3), ffv);
        if (ffv != 0) check_eq({tag, "_d3_ff"}, int'(ff3), ff);
    endtask

    // Start both instances, optionally pulse start again at vec_o==poke,
    // and measure the start-to-done latency of each.
    task automatic run_sweep(input string tag, input int poke);
        int k;
        bit bad;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_start_busy"}, int'(busy0 & busy3), 1);
        check_eq({tag, "_start_done"}, int'(done0 | done3), 0);
        check_eq({tag, "_start_vec"}, int'(v0), 0);
        check_eq({tag, "_start_vvalid"}, int'(vv0), 1);
        check_eq({tag, "_start_cnt"}, int'(fail0) + int'(err0) + int'(ffv0), 0);
        @(negedge clk);
        start = 1'b0;
        k = 0; lat0 = -1; lat3 = -1; bad = 1'b0;
        while ((lat0 < 0 || lat3 < 0) && k < 3000) begin
            start = (poke >= 0 && int'(v0) == poke && vv0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            k++;
            if (done0 && lat0 < 0) lat0 = k + 1;
            if (done3 && lat3 < 0) lat3 = k + 1;
            if ((busy0 && done0) || (busy3 && done3)) bad = 1'b1;
            if (lat0 < 0 && !busy0 && !done0) bad = 1'b1;
            if (lat3 < 0 && !busy3 && !done3) bad = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq({tag, "_lat0"}, lat0, 2050);
        check_eq({tag, "_lat3"}, lat3, 2053);
        check_eq({tag, "_busy_done_excl"}, int'(bad), 0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        start   = 1'b0;
        stages3 = 3;
        for (int k = 0; k < NV; k++) begin
            gold_tab[k] = 2'b00;
            dut_tab[k]  = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy0 | busy3), 0);
        check_eq("rst_done", int'(done0 | done3), 0);
        check_eq("rst_vec", int'(v0) + int'(vv0), 0);
        check_eq("rst_cnt", int'(err0) + int'(fail0) + int'(ff0) + int'(ffv0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: matched random tables
        for (int k = 0; k < NV; k++) begin
            gold_tab[k] = 2'($urandom_range(0, 3));
            dut_tab[k]  = gold_tab[k];
        end
        run_sweep("s1", -1);
        check_results("s1", 0);

        // 2: golden zero, DUT 2'b10 at vectors 5 and 2047
        for (int k = 0; k < NV; k++) begin
            gold_tab[k] = 2'b00;
            dut_tab[k]  = 2'b00;
        end
        dut_tab[5]    = 2'b10;
        dut_tab[2047] = 2'b10;
        run_sweep("s2", -1);
        check_results("s2", 0);
        check_eq("s2_err1_const", int'(err0[23:12]), 2);
        check_eq("s2_ff_const", int'(ff0), 5);

        // 3: golden zero, DUT constant 2'b11, counters reach 2048
        for (int k = 0; k < NV; k++) dut_tab[k] = 2'b11;
        run_sweep("s3", -1);
        check_results("s3", 0);
        check_eq("s3_fail_const", int'(fail0), 2048);
        check_eq("s3_err0_d3_const", int'(err3[11:0]), 2048);

        // 4: sparse random mismatches, stray start at vec 50 ignored
        for (int k = 0; k < NV; k++) begin
            gold_tab[k] = 2'($urandom_range(0, 3));
            dut_tab[k]  = gold_tab[k];
            if ($urandom_range(0, 15) == 0) dut_tab[k] = gold_tab[k] ^ 2'($urandom_range(1, 3));
        end
        run_sweep("s4", 50);
        check_results("s4", 0);

        // 5: registered DUT one stage short of the declared latency
        stages3 = 2;
        for (int k = 0; k < NV; k++) begin
            gold_tab[k] = 2'($urandom_range(0, 3));
            dut_tab[k]  = gold_tab[k];
        end
        run_sweep("s5", -1);
        check_results("s5", 1);
        check_eq("s5_d3_nonzero", int'(fail3 != 12'd0), 1);
        stages3 = 3;

        // 6: reset mid-sweep at vec 100, then a fresh matched sweep
        for (int k = 0; k < NV; k++) begin
            gold_tab[k] = 2'($urandom_range(0, 3));
            dut_tab[k]  = gold_tab[k] ^ 2'(k[0]);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (int'(v0) != 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("s6_reach_100", int'(v0), 100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("s6_rst_vec", int'(v0) + int'(vv0), 0);
        check_eq("s6_rst_busy", int'(busy0 | busy3 | done0 | done3), 0);
        check_eq("s6_rst_cnt", int'(err0) + int'(fail0) + int'(ff0) + int'(ffv0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("s6_post_cnt", int'(err0) + int'(fail0) + int'(err3) + int'(fail3), 0);
        check_eq("s6_post_idle", int'(busy0 | busy3 | done0 | done3), 0);
        for (int k = 0; k < NV; k++) dut_tab[k] = gold_tab[k];
        run_sweep("s6", -1);
        check_results("s6", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
